music_effect_sequencer: RTL and testbench
=========================================

MUSIC_EFFECT_SEQUENCER -- requirements
Module: music_effect_sequencer

Interface
REQ-001 Parameter BEAT_DIV, default 50000, clk cycles per beat; legal range 2..2^20.
REQ-002 Parameter STEPS, default 8, number of pattern-table entries; fixed power of two; step index width 3.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  pulse; begin pattern playback from step 0.
REQ-006 stop  in  1  pulse; abort playback and return to idle.
REQ-007 hold  in  1  level; freeze playback while high.
REQ-008 loop_last  in  3  index of last step before wrap to 0.
REQ-009 wr_en  in  1  pattern-table write strobe.
REQ-010 wr_addr  in  3  table entry written.
REQ-011 wr_data  in  3  mode word: [1:0] octave (00 none, 01 down, 10 up, 11 none), [2] tremolo.
REQ-012 octave_dena  out  1  octave-down enable to effect datapath.
REQ-013 octave_uena  out  1  octave-up enable to effect datapath.
REQ-014 tremolo_ena  out  1  tremolo enable to effect datapath.
REQ-015 led_ena  out  1  step-indicator LED enable.
REQ-016 busy  out  1  high in RUN or HOLD.
REQ-017 step  out  3  current step index.

Function
REQ-018 FSM states SHALL be IDLE, RUN, HOLD.
REQ-019 IDLE->RUN on start (stop low); step<=0, beat counter<=0, effect outputs<=decode(table[0]) on same edge (visible cycle after start).
REQ-020 RUN->HOLD when hold high; HOLD->RUN when hold low; in HOLD beat counter, step and outputs SHALL freeze.
REQ-021 RUN/HOLD->IDLE on stop; stop SHALL win over simultaneous start or hold; IDLE outputs all 0, step 0.
REQ-022 start in RUN/HOLD SHALL restart at step 0 with counter cleared.
REQ-023 Beat counter SHALL count 0..BEAT_DIV-1 in RUN only; beat tick when counter == BEAT_DIV-1, counter then wraps to 0.
REQ-024 On tick: step <= (step == loop_last || step == 7) ? 0 : step+1; outputs <= decode(table[next step]) on same edge.
REQ-025 loop_last change mid-run SHALL apply at next tick; if step > new loop_last, next tick wraps to 0.
REQ-026 Octave code 11 SHALL decode as none; octave_dena and octave_uena SHALL never both be 1.
REQ-027 Table writes SHALL be accepted in any state; write to the step currently playing SHALL take effect at its next visit, not immediately.
REQ-028 Write and read of same entry on same edge SHALL read old data.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, step 0, counter 0, all outputs 0, table entries to 000.
REQ-030 Reset mid-playback SHALL abandon playback; no output glitch beyond the asynchronous clear.

Configuration
REQ-031 Macro MUSICFX_LED_EN defined: led_ena SHALL toggle on every beat tick in RUN, 0 in IDLE, frozen in HOLD.
REQ-032 Macro MUSICFX_LED_EN undefined: led_ena SHALL be constant 0 and toggle logic absent.

Structure
REQ-033 Package musicfx_pkg SHALL hold FSM state enum, octave code constants, mode-word field positions, and decode function.
REQ-034 Sub-module beat_prescaler (clk, rst_n, run, clear -> tick) SHALL implement the beat counter.

Verification (BEAT_DIV=4)
REQ-035 Write table[0]=001, table[1]=110, loop_last=1, start -> octave_dena=1 cycles 1-4, then octave_uena=1 & tremolo_ena=1 cycles 5-8, then step 0 again.
REQ-036 Running, hold high 10 cycles -> step, outputs, counter unchanged; release -> remaining beat cycles resume exactly.
REQ-037 start and stop same cycle in RUN -> IDLE, all outputs 0, busy 0.
REQ-038 Write 011 to table[2] -> when step 2 plays, octave_dena=0, octave_uena=0.
REQ-039 rst_n low mid-beat at step 3 -> outputs 0 immediately; after release table reads 000.
REQ-040 MUSICFX_LED_EN defined, loop_last=7, 8 beats -> led_ena toggles 8 times; undefined -> led_ena stays 0.

Source files
------------

// File: rtl/musicfx_pkg.sv
// musicfx_pkg: shared types and helpers for the music effect sequencer.
//   state_t      FSM state encoding (IDLE / RUN / HOLD)
//   OCT_*        octave field codes of the 3-bit pattern mode word
//   MODE_*       bit positions of the mode-word fields
//   fx_t         decoded effect enables
//   decode_mode  mode word -> effect enables (octave code 11 treated as none)
package musicfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OCT_NONE     = 2'b00;
  localparam logic [1:0] OCT_DOWN     = 2'b01;
  localparam logic [1:0] OCT_UP       = 2'b10;
  localparam logic [1:0] OCT_NONE_ALT = 2'b11;

  localparam int MODE_W        = 3;
  localparam int MODE_OCT_LSB  = 0;
  localparam int MODE_OCT_MSB  = 1;
  localparam int MODE_TREM_BIT = 2;

  typedef struct packed {
    logic oct_down;
    logic oct_up;
    logic tremolo;
  } fx_t;

  // Exact-match compares keep down/up mutually exclusive by construction.
  function automatic fx_t decode_mode(input logic [MODE_W-1:0] mode);
    fx_t fx;
    fx.oct_down = (mode[MODE_OCT_MSB:MODE_OCT_LSB] == OCT_DOWN);
    fx.oct_up   = (mode[MODE_OCT_MSB:MODE_OCT_LSB] == OCT_UP);
    fx.tremolo  = mode[MODE_TREM_BIT];
    return fx;
  endfunction

endpackage

// File: rtl/music_effect_sequencer_beat_prescaler.sv
// beat_prescaler: beat counter for the music effect sequencer.
//   clk, rst_n  clock / async active-low reset
//   run         count enable (counter frozen when low)
//   clear       synchronous return to 0, overrides run
//   tick        high for the cycle in which the counter sits at BEAT_DIV-1 while running
module beat_prescaler #(
  parameter int BEAT_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(BEAT_DIV);
  localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/music_effect_sequencer.sv
// music_effect_sequencer: steps through an 8-entry pattern table once per beat
// and drives octave-down / octave-up / tremolo enables to the effect datapath.
//   clk, rst_n           clock / async active-low reset (clears table too)
//   start, stop          playback pulses; stop wins over start and hold
//   hold                 level, freezes counter, step and outputs
//   loop_last            last step before wrapping to 0
//   wr_en/addr/data      pattern-table write port, accepted in any state
//   octave_dena/uena, tremolo_ena, led_ena, busy, step   status / enables
// Build option: MUSICFX_LED_EN adds a beat-tick toggling LED; otherwise led_ena is 0.
//
// state   | meaning
// IDLE    | not playing, outputs and step at 0
// RUN     | beat counter running, step advances on each tick
// HOLD    | playback frozen while hold is high
module music_effect_sequencer
  import musicfx_pkg::*;
#(
  parameter int BEAT_DIV = 50000,
  parameter int STEPS    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic [2:0]        loop_last,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [MODE_W-1:0] wr_data,
  output logic              octave_dena,
  output logic              octave_uena,
  output logic              tremolo_ena,
  output logic              led_ena,
  output logic              busy,
  output logic [2:0]        step
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MODE_W-1:0] r_table [STEPS];
  logic [2:0]        r_step;
  fx_t               r_fx;

  logic       w_busy;
  logic       w_start;
  logic       w_stop;
  logic       w_advance;
  logic       w_tick;
  logic [2:0] w_step_nxt;
  logic [2:0] w_rd_idx;
  fx_t        w_fx_rd;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_start   = start && !stop;
  assign w_stop    = stop && w_busy;
  // Counting is gated by the hold level itself so a hold costs exactly its
  // own length in cycles and release resumes the beat without a dead cycle.
  assign w_advance = w_busy && !hold && !stop && !start;

  // ">=" rather than "==" so a loop_last lowered below the current step wraps on the next tick.
  assign w_step_nxt = ((r_step >= loop_last) || (r_step == 3'(STEPS - 1))) ? 3'd0 : r_step + 3'd1;
  assign w_rd_idx   = w_start ? 3'd0 : w_step_nxt;
  // Table is read before this edge's write lands, so a same-edge write reads old data.
  assign w_fx_rd    = decode_mode(r_table[w_rd_idx]);

  beat_prescaler #(.BEAT_DIV(BEAT_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_advance),
    .clear (start || stop),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (stop)      w_state_nxt = ST_IDLE;
        else if (hold) w_state_nxt = ST_HOLD;
        else           w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
      r_fx   <= '0;
    end else if (w_start) begin
      r_step <= '0;
      r_fx   <= w_fx_rd;
    end else if (w_stop) begin
      r_step <= '0;
      r_fx   <= '0;
    end else if (w_tick) begin
      r_step <= w_step_nxt;
      r_fx   <= w_fx_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) r_table[i] <= '0;
    end else if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

`ifdef MUSICFX_LED_EN
  logic r_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_led <= 1'b0;
    else if (w_start || w_stop) r_led <= 1'b0;
    else if (w_tick)            r_led <= ~r_led;
  end

  assign led_ena = r_led;
`else
  assign led_ena = 1'b0;
`endif

  assign octave_dena = r_fx.oct_down;
  assign octave_uena = r_fx.oct_up;
  assign tremolo_ena = r_fx.tremolo;
  assign busy        = w_busy;
  assign step        = r_step;

endmodule

// File: tb/tb_music_effect_sequencer.sv
module tb_music_effect_sequencer;

  localparam int BD = 4;
`ifdef MUSICFX_LED_EN
  localparam bit LED_ON = 1'b1;
`else
  localparam bit LED_ON = 1'b0;
`endif

  logic       clk, rst_n, start, stop, hold, wr_en;
  logic [2:0] loop_last, wr_addr, wr_data;
  logic       octave_dena, octave_uena, tremolo_ena, led_ena, busy;
  logic [2:0] step;

  music_effect_sequencer #(.BEAT_DIV(BD), .STEPS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .loop_last(loop_last), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .octave_dena(octave_dena), .octave_uena(octave_uena), .tremolo_ena(tremolo_ena),
    .led_ena(led_ena), .busy(busy), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [2:0] fx;   // {dena, uena, trem}
  } vec_t;

  vec_t        vt[8];
  logic [7:0]  q_exp[$];
  int          n_chk = 0;
  int          n_err = 0;

  // scoreboard model state
  bit          m_busy;
  logic [2:0]  m_step;
  int          m_cnt;
  logic [2:0]  m_fx;
  bit          m_led;
  logic [2:0]  tbl_m[8];

  function automatic logic [7:0] sample();
    return {busy, step, octave_dena, octave_uena, tremolo_ena, led_ena};
  endfunction

  function automatic logic [2:0] dec(input logic [2:0] md);
    case (md)
      3'b001:  return 3'b100;
      3'b010:  return 3'b010;
      3'b100:  return 3'b001;
      3'b101:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_step = 0; m_cnt = 0; m_fx = 0; m_led = 0;
    for (int i = 0; i < 8; i++) tbl_m[i] = 3'b000;
  endtask

  // One clock: update model, push expectation, drive, clock, pop and compare.
  task automatic go(input logic st, input logic sp, input logic hd, input logic we,
                    input logic [2:0] wa, input logic [2:0] wd, input string nm);
    logic [2:0] nx;
    if (sp) begin
      m_busy = 0; m_step = 0; m_cnt = 0; m_fx = 0; m_led = 0;
    end else if (st) begin
      m_busy = 1; m_step = 0; m_cnt = 0; m_fx = dec(tbl_m[0]); m_led = 0;
    end else if (m_busy && !hd) begin
      if (m_cnt == BD - 1) begin
        m_cnt  = 0;
        nx     = (m_step >= loop_last) ? 3'd0 : m_step + 3'd1;
        m_step = nx;
        m_fx   = dec(tbl_m[nx]);
        m_led  = m_led ^ LED_ON;
      end else begin
        m_cnt++;
      end
    end
    if (we) tbl_m[wa] = wd;
    q_exp.push_back({m_busy, m_step, m_fx, m_led});
    start = st; stop = sp; hold = hd; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk); #1;
    start = 0; stop = 0; wr_en = 0;
    chk(nm, sample(), q_exp.pop_front());
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] d);
    go(0, 0, 0, 1, a, d, "write");
  endtask

  task automatic run(input int n, input string nm);
    for (int i = 0; i < n; i++) go(0, 0, 0, 0, 3'd0, 3'd0, nm);
  endtask

  initial begin
    int toggles;
    logic prev_led;
    vt[0] = '{3'b000, 3'b000}; vt[1] = '{3'b001, 3'b100};
    vt[2] = '{3'b010, 3'b010}; vt[3] = '{3'b011, 3'b000};
    vt[4] = '{3'b100, 3'b001}; vt[5] = '{3'b101, 3'b101};
    vt[6] = '{3'b110, 3'b011}; vt[7] = '{3'b111, 3'b001};

    rst_n = 0; start = 0; stop = 0; hold = 0; wr_en = 0;
    wr_addr = 0; wr_data = 0; loop_last = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", sample(), 8'h00);
    rst_n = 1;

    // decode table: every mode word through entry 0
    for (int i = 0; i < 8; i++) begin
      wr(3'd0, vt[i].mode);
      go(1, 0, 0, 0, 3'd0, 3'd0, "decode_start");
      chk("decode_vec", {5'b0, octave_dena, octave_uena, tremolo_ena}, {5'b0, vt[i].fx});
      go(0, 1, 0, 0, 3'd0, 3'd0, "decode_stop");
    end

    // two-step loop, 4 cycles per beat
    loop_last = 3'd1;
    wr(3'd0, 3'b001);
    wr(3'd1, 3'b110);
    for (int c = 1; c <= 12; c++) begin
      go(c == 1, 0, 0, 0, 3'd0, 3'd0, "loop2");
      chk("loop2_oct", {6'b0, octave_dena, octave_uena},
          {6'b0, (c <= 4 || c >= 9), (c >= 5 && c <= 8)});
    end
    go(0, 1, 0, 0, 3'd0, 3'd0, "loop2_stop");

    // hold for 10 cycles after 2 beat cycles, then the remaining 2 cycles
    go(1, 0, 0, 0, 3'd0, 3'd0, "hold_start");
    run(1, "hold_pre");
    for (int c = 0; c < 10; c++) begin
      go(0, 0, 1, 0, 3'd0, 3'd0, "hold_frozen");
      chk("hold_step", {5'b0, step}, 8'd0);
    end
    for (int r = 1; r <= 6; r++) begin
      go(0, 0, 0, 0, 3'd0, 3'd0, "hold_resume");
      chk("hold_resume_step", {5'b0, step}, (r <= 2) ? 8'd0 : 8'd1);
    end

    // start and stop together while running
    go(1, 1, 0, 0, 3'd0, 3'd0, "start_stop");
    chk("start_stop_idle", sample(), 8'h00);

    // writes to the playing entry, including a write on the tick edge
    loop_last = 3'd0;
    wr(3'd0, 3'b001);
    for (int c = 1; c <= 13; c++) begin
      go(c == 1, 0, 0, c == 2 || c == 9, 3'd0, (c == 2) ? 3'b010 : 3'b100, "wr_playing");
      if (c == 2)  chk("wr_not_immediate", {5'b0, octave_dena, octave_uena, tremolo_ena}, 8'b100);
      if (c == 5)  chk("wr_next_visit",    {5'b0, octave_dena, octave_uena, tremolo_ena}, 8'b010);
      if (c == 9)  chk("wr_same_edge_old", {5'b0, octave_dena, octave_uena, tremolo_ena}, 8'b010);
      if (c == 13) chk("wr_same_edge_new", {5'b0, octave_dena, octave_uena, tremolo_ena}, 8'b001);
    end
    go(0, 1, 0, 0, 3'd0, 3'd0, "wr_stop");

    // octave code 11, loop_last lowered mid-run, restart, reset mid-beat
    loop_last = 3'd7;
    wr(3'd1, 3'b000);
    wr(3'd2, 3'b011);
    wr(3'd3, 3'b110);
    for (int c = 1; c <= 14; c++) begin
      go(c == 1, 0, 0, 0, 3'd0, 3'd0, "oct11_run");
      if (c >= 9 && c <= 12)
        chk("oct11", {6'b0, octave_dena, octave_uena}, 8'd0);
    end
    loop_last = 3'd1;
    run(2, "ll_change_hold_step");
    chk("ll_step3", {5'b0, step}, 8'd3);
    run(1, "ll_change_wrap");
    chk("ll_wrap", {5'b0, step}, 8'd0);
    run(1, "ll_after");
    for (int c = 1; c <= 5; c++) begin
      go(c == 1, 0, 0, 0, 3'd0, 3'd0, "restart");
      chk("restart_step", {5'b0, step}, (c <= 4) ? 8'd0 : 8'd1);
    end
    loop_last = 3'd7;
    run(9, "to_step3");
    chk("pre_reset_step3", {5'b0, step}, 8'd3);
    rst_n = 0;
    #1;
    chk("reset_async", sample(), 8'h00);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 1; c <= 16; c++) begin
      go(c == 1, 0, 0, 0, 3'd0, 3'd0, "post_reset_run");
      chk("table_cleared", {5'b0, octave_dena, octave_uena, tremolo_ena}, 8'd0);
    end

    // LED over 8 beats with full loop
    go(0, 1, 0, 0, 3'd0, 3'd0, "led_stop");
    loop_last = 3'd7;
    go(1, 0, 0, 0, 3'd0, 3'd0, "led_start");
    toggles  = 0;
    prev_led = led_ena;
    for (int c = 2; c <= 33; c++) begin
      run(1, "led_run");
      if (led_ena !== prev_led) toggles++;
      prev_led = led_ena;
    end
    chk("led_toggles", 8'(toggles), LED_ON ? 8'd8 : 8'd0);
    chk("led_wrap_step", {5'b0, step}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
